// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-side bundle for fetch_pc_ctrl: redirect input, instruction-memory
// port, and the IF/ID delivery slot. The master side is the sequencer.
interface fetch_pc_ctrl_if;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        id_stall;
  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic        ifetch_ack;
  logic [31:0] ifetch_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        flush;
  logic        redirect_pending;

  modport master (
    input  redir_valid, redir_pc, id_stall, ifetch_ack, ifetch_data,
    output ifetch_req, ifetch_addr, inst_valid, inst, inst_pc, flush,
           redirect_pending
  );

  modport slave (
    output redir_valid, redir_pc, id_stall, ifetch_ack, ifetch_data,
    input  ifetch_req, ifetch_addr, inst_valid, inst, inst_pc, flush,
           redirect_pending
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: owns the PC, issues instruction-memory requests, orders
// redirects against in-flight fetches and feeds IF/ID through a skid slot.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  fetch_pc_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        outstanding, outstanding_nxt;
  logic        inst_valid, inst_valid_nxt;
  logic [31:0] inst, inst_nxt;
  logic [31:0] inst_pc, inst_pc_nxt;
  logic        skid_v, skid_v_nxt;
  logic [31:0] skid_inst, skid_inst_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic        pend_v, pend_v_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;

  logic        req;
  logic        ack;
  logic        slot_free;
  logic [31:0] redir_aligned;

  assign redir_aligned = bus.redir_pc & ~32'h0000_0003;

  // Next-state and request decode; redirect outranks ack and HOLD release.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    outstanding_nxt = outstanding;
    inst_valid_nxt  = inst_valid;
    inst_nxt        = inst;
    inst_pc_nxt     = inst_pc;
    skid_v_nxt      = skid_v;
    skid_inst_nxt   = skid_inst;
    skid_pc_nxt     = skid_pc;
    pend_v_nxt      = pend_v;
    pend_pc_nxt     = pend_pc;
    req             = 1'b0;

    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   req = outstanding | ~(inst_valid & bus.id_stall);
      HOLD:    req = 1'b0;
      default: state_nxt = BOOT;
    endcase

    ack       = req & bus.ifetch_ack;
    slot_free = ~inst_valid | ~bus.id_stall;

    if (inst_valid && !bus.id_stall) begin
      inst_valid_nxt = 1'b0;
    end
    if (state == FETCH) begin
      outstanding_nxt = req & ~ack;
    end

    if (bus.redir_valid) begin
      inst_valid_nxt = 1'b0;
      skid_v_nxt     = 1'b0;
      if (req && !ack) begin
        // The memory still owns ifetch_addr; park the target until its ack.
        pend_v_nxt  = 1'b1;
        pend_pc_nxt = redir_aligned;
      end else begin
        pc_nxt     = redir_aligned;
        pend_v_nxt = 1'b0;
        state_nxt  = FETCH;
      end
    end else if (ack) begin
      if (pend_v) begin
        pc_nxt     = pend_pc;
        pend_v_nxt = 1'b0;
      end else begin
        pc_nxt = pc + 32'd4;
        if (slot_free) begin
          inst_valid_nxt = 1'b1;
          inst_nxt       = bus.ifetch_data;
          inst_pc_nxt    = pc;
        end else begin
          skid_v_nxt    = 1'b1;
          skid_inst_nxt = bus.ifetch_data;
          skid_pc_nxt   = pc;
          state_nxt     = HOLD;
        end
      end
    end else if (state == HOLD && !bus.id_stall) begin
      inst_valid_nxt = 1'b1;
      inst_nxt       = skid_inst;
      inst_pc_nxt    = skid_pc;
      skid_v_nxt     = 1'b0;
      state_nxt      = FETCH;
    end
  end

  // State register.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Control and output slot; the slot contents are architecturally reset.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc          <= RESET_PC;
      outstanding <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= 32'd0;
      inst_pc     <= 32'd0;
      skid_v      <= 1'b0;
      pend_v      <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      outstanding <= outstanding_nxt;
      inst_valid  <= inst_valid_nxt;
      inst        <= inst_nxt;
      inst_pc     <= inst_pc_nxt;
      skid_v      <= skid_v_nxt;
      pend_v      <= pend_v_nxt;
    end
  end

  // Payload qualified by skid_v / pend_v.
  always_ff @(posedge cpu_clk) begin
    skid_inst <= skid_inst_nxt;
    skid_pc   <= skid_pc_nxt;
    pend_pc   <= pend_pc_nxt;
  end

  assign bus.ifetch_req       = req;
  assign bus.ifetch_addr      = pc;
  assign bus.inst_valid       = inst_valid;
  assign bus.inst             = inst;
  assign bus.inst_pc          = inst_pc;
  assign bus.flush            = bus.redir_valid;
  assign bus.redirect_pending = pend_v;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios then randomized traffic, all
// checked against a queue-based model of the delivered instruction stream.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic cpu_clk;
  logic cpu_rst;
  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int vectors;
  int miscompares;

  // Model: instructions waiting for decode, in order (entry 0 is on inst).
  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } ent_t;
  ent_t        held[$];
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_busy;
  logic        m_pend;
  logic [31:0] m_ppc;

  logic        s_req, s_flush, s_valid, s_pend;
  logic [31:0] s_addr, s_inst, s_ipc;

  function automatic logic [31:0] dword(logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic m_reset();
    held.delete();
    m_pc   = RST_PC;
    m_boot = 1'b1;
    m_busy = 1'b0;
    m_pend = 1'b0;
    m_ppc  = 32'd0;
  endtask

  function automatic logic m_req(logic stall);
    return !m_boot && held.size() < 2 &&
           (m_busy || !(held.size() == 1 && stall));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step(logic rst, logic rv, logic [31:0] rpc, logic stall,
                      logic ack, logic [31:0] data);
    logic mr;
    logic a;
    cpu_rst         = rst;
    bus.redir_valid = rv;
    bus.redir_pc    = rpc;
    bus.id_stall    = stall;
    bus.ifetch_ack  = ack;
    bus.ifetch_data = data;
    @(negedge cpu_clk);
    s_req = bus.ifetch_req;  s_addr = bus.ifetch_addr; s_flush = bus.flush;
    s_valid = bus.inst_valid; s_inst = bus.inst; s_ipc = bus.inst_pc;
    s_pend = bus.redirect_pending;
    mr = m_req(stall);
    chk("req", {31'd0, s_req}, {31'd0, mr});
    chk("addr", s_addr, m_pc);
    chk("flush", {31'd0, s_flush}, {31'd0, rv});
    chk("pending", {31'd0, s_pend}, {31'd0, m_pend});
    chk("valid", {31'd0, s_valid}, {31'd0, held.size() > 0});
    if (held.size() > 0) begin
      chk("inst", s_inst, held[0].w);
      chk("inst_pc", s_ipc, held[0].a);
    end
    a = mr && ack;
    if (rst) begin
      m_reset();
    end else begin
      if (rv) begin
        held.delete();
        if (mr && !a) begin
          m_pend = 1'b1; m_ppc = {rpc[31:2], 2'b00}; m_busy = 1'b1;
        end else begin
          m_pc = {rpc[31:2], 2'b00}; m_pend = 1'b0; m_busy = 1'b0;
        end
      end else begin
        if (held.size() > 0 && !stall) void'(held.pop_front());
        if (a) begin
          m_busy = 1'b0;
          if (m_pend) begin
            m_pc = m_ppc; m_pend = 1'b0;
          end else begin
            held.push_back('{data, m_pc});
            m_pc = m_pc + 32'd4;
          end
        end else begin
          m_busy = mr;
        end
      end
      m_boot = 1'b0;
    end
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cpu_rst = 1'b1;
    bus.redir_valid = 1'b0; bus.redir_pc = 32'd0; bus.id_stall = 1'b0;
    bus.ifetch_ack = 1'b0;  bus.ifetch_data = 32'd0;
    @(posedge cpu_clk);
    #1;
    m_reset();
    chk("rst_req", {31'd0, bus.ifetch_req}, 32'd0);
    chk("rst_addr", bus.ifetch_addr, RST_PC);
    chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_pend", {31'd0, bus.redirect_pending}, 32'd0);
    step(1, 0, 0, 0, 0, 0);

    // Zero-wait memory, no stalls.
    step(0, 0, 0, 0, 0, 0);
    chk("s1_boot_req", {31'd0, s_req}, 32'd0);
    chk("s1_valid_e1", {31'd0, bus.inst_valid}, 32'd0);
    step(0, 0, 0, 0, 1, dword(32'h1C00_0000));
    chk("s1_addr0", s_addr, 32'h1C00_0000);
    chk("s1_valid_e2", {31'd0, bus.inst_valid}, 32'd1);
    chk("s1_ipc0", bus.inst_pc, 32'h1C00_0000);
    step(0, 0, 0, 0, 1, dword(32'h1C00_0004));
    chk("s1_addr1", s_addr, 32'h1C00_0004);
    chk("s1_ipc1", bus.inst_pc, 32'h1C00_0004);
    step(0, 0, 0, 0, 1, dword(32'h1C00_0008));
    chk("s1_addr2", s_addr, 32'h1C00_0008);

    // Decode stall holds the output; nothing is lost after release.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("s2_req", {31'd0, s_req}, 32'd0);
      chk("s2_inst", bus.inst, dword(32'h1C00_0008));
      chk("s2_ipc", bus.inst_pc, 32'h1C00_0008);
    end
    step(0, 0, 0, 0, 1, dword(32'h1C00_000C));
    chk("s2_next_ipc", bus.inst_pc, 32'h1C00_000C);

    // Redirect with zero-wait fetch.
    step(0, 1, 32'h1C00_0100, 0, 1, 32'hDEAD_0001);
    chk("s3_flush", {31'd0, s_flush}, 32'd1);
    chk("s3_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("s3_addr", bus.ifetch_addr, 32'h1C00_0100);
    step(0, 0, 0, 0, 1, dword(32'h1C00_0100));
    chk("s3_ipc", bus.inst_pc, 32'h1C00_0100);

    // Redirect while the memory is waiting.
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1C00_0200, 0, 0, 0);
    chk("s4_pend", {31'd0, bus.redirect_pending}, 32'd1);
    chk("s4_addr_held", bus.ifetch_addr, 32'h1C00_0104);
    step(0, 0, 0, 0, 0, 0);
    chk("s4_addr_held2", bus.ifetch_addr, 32'h1C00_0104);
    step(0, 0, 0, 0, 1, 32'hDEAD_0002);
    chk("s4_dropped", {31'd0, bus.inst_valid}, 32'd0);
    chk("s4_pend_clr", {31'd0, bus.redirect_pending}, 32'd0);
    chk("s4_addr_tgt", bus.ifetch_addr, 32'h1C00_0200);
    step(0, 0, 0, 0, 1, dword(32'h1C00_0200));
    chk("s4_ipc", bus.inst_pc, 32'h1C00_0200);

    // Redirect together with a decode stall on a live output.
    step(0, 1, 32'h1C00_0300, 1, 0, 0);
    chk("s5_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("s5_addr", bus.ifetch_addr, 32'h1C00_0300);
    step(0, 0, 0, 1, 1, dword(32'h1C00_0300));
    chk("s5_ipc", bus.inst_pc, 32'h1C00_0300);

    // Misaligned target and wrap-around.
    step(0, 1, 32'hFFFF_FFFE, 0, 1, 32'hDEAD_0003);
    chk("s6_align", bus.ifetch_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, dword(32'hFFFF_FFFC));
    chk("s6_wrap", bus.ifetch_addr, 32'h0000_0000);
    chk("s6_ipc", bus.inst_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, dword(32'h0000_0000));
    chk("s6_ipc0", bus.inst_pc, 32'h0000_0000);

    // Reset with a fetch outstanding; the late ack is ignored.
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("s7_addr", bus.ifetch_addr, RST_PC);
    step(0, 0, 0, 0, 1, 32'hDEAD_0004);
    chk("s7_req", {31'd0, s_req}, 32'd0);
    chk("s7_valid", {31'd0, bus.inst_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("s7_refetch", s_addr, RST_PC);

    // Randomized traffic with variable memory latency.
    for (int i = 0; i < 3000; i++) begin
      logic r, rv, st, ak;
      r  = ($urandom % 200) == 0;
      rv = ($urandom % 10) == 0;
      st = ($urandom % 4) == 0;
      ak = m_req(st) && (($urandom % 3) != 0);
      step(r, rv, $urandom, st, ak, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Front-end fetch sequencer that owns the architectural PC and drives the instruction-memory request port. Each cycle it decides the next fetch address: sequential PC+4, or the redirect target produced by the next-PC unit when a branch or jump resolves taken. It sequences redirects against outstanding fetches and decode stalls, so the fetch address never changes mid-transaction. It delivers fetched instructions to IF/ID through a one-entry skid buffer and asserts `flush` for the younger stages.

## Interface
- RESET_PC, 32'h1C00_0000, PC fetched first after reset
- cpu_clk  in  1  clock, all state updates on rising edge
- cpu_rst  in  1  reset, synchronous, active-high
- redir_valid  in  1  taken redirect this cycle (next-PC unit jump enable)
- redir_pc  in  32  redirect target (next-PC unit output)
- id_stall  in  1  decode cannot accept; held output must not advance
- ifetch_req  out  1  fetch request to instruction memory
- ifetch_addr  out  32  fetch address, equals internal pc
- ifetch_ack  in  1  memory returns data this cycle for the current request
- ifetch_data  in  32  instruction word, valid with ifetch_ack
- inst_valid  out  1  inst/inst_pc hold a live instruction for IF/ID
- inst  out  32  instruction word
- inst_pc  out  32  address of inst
- flush  out  1  kill younger instructions in IF/ID and ID/EX
- redirect_pending  out  1  redirect buffered behind an outstanding fetch

## Operation
- Registers:
  - pc
  - state {BOOT, FETCH, HOLD}
  - outstanding flag
  - output slot (inst_valid/inst/inst_pc)
  - skid slot (skid_v/skid_inst/skid_pc)
  - pending slot (pend_v/pend_pc)
- Reset values:
  - pc = RESET_PC, state = BOOT
  - all valid bits, outstanding and pending = 0
  - inst = inst_pc = 0
  - ifetch_req = 0, ifetch_addr = RESET_PC, flush = 0
- BOOT: ifetch_req = 0. Moves unconditionally to FETCH next cycle.
- FETCH:
  - ifetch_req = outstanding OR NOT(inst_valid AND id_stall).
  - Once raised, the request and ifetch_addr are held until ifetch_ack.
  - Outstanding is set when a request is raised without ack, and cleared on ack.
- Output slot consumption: the slot is consumed at an edge where inst_valid = 1 and id_stall = 0.
- Ack without redirect:
  - pc <= pc + 4 (mod 2^32).
  - If the slot is free or consumed this edge: the slot loads {ifetch_data, pc} and state stays FETCH.
  - Otherwise: skid loads {ifetch_data, pc} and state goes to HOLD.
- HOLD:
  - ifetch_req = 0.
  - When id_stall = 0: skid moves into the output slot, skid_v <= 0, state goes to FETCH.
- Redirect handling (redir_valid = 1) takes priority over everything except reset:
  - flush = redir_valid, combinational, same cycle.
  - inst_valid <= 0 and skid_v <= 0, regardless of id_stall.
  - No request in flight, or ack this cycle: pc <= redir_pc, any returning data is discarded, state goes to FETCH.
  - Request outstanding and no ack: pend_v <= 1, pend_pc <= redir_pc. ifetch_addr stays unchanged.
- Pending redirect:
  - On the ack that completes the outstanding fetch, the data is discarded, pc <= pend_pc and pend_v <= 0.
  - A second redir_valid while pend_v = 1 overwrites pend_pc (latest wins).
  - redirect_pending = pend_v.
- Target alignment: redir_pc[1:0] is ignored; pc takes {redir_pc[31:2], 2'b00}.
- Reset mid-operation (any state): all registers return to reset values next edge. An in-flight memory response is ignored.

## Timing
- Zero-wait memory (ack in the same cycle as req) gives one instruction per cycle.
  - First inst_valid appears two edges after reset deasserts: BOOT, then FETCH with ack.
- Fetch-to-output latency: the data returned with ack appears on inst one edge later.
- Redirect-to-new-path: with no outstanding fetch, a request to the target issues the cycle after redir_valid. Its instruction is valid one edge after its ack.
- flush is never registered. It is high in exactly the cycles redir_valid is high.
- inst/inst_pc are stable whenever inst_valid = 1 and id_stall = 1.

## Test plan
- Reset, zero-wait memory, no stalls:
  - ifetch_addr follows 1C00_0000, 1C00_0004, 1C00_0008.
  - inst_valid first rises at the 2nd edge.
  - inst_pc tracks the address one cycle behind.
- Decode stall with ack landing on a held output:
  - id_stall high for 3 cycles while an ack arrives → state HOLD, ifetch_req = 0, inst unchanged.
  - After release, the skid word appears with inst_pc = previous + 4 and no instruction is lost.
- Redirect with zero-wait fetch:
  - redir_valid = 1, redir_pc = 1C00_0100 → flush = 1 that cycle, inst_valid = 0 next edge.
  - The next ifetch_addr is 1C00_0100.
- Redirect during a 3-cycle memory wait:
  - redirect to 1C00_0200 in wait cycle 1 → redirect_pending = 1 and ifetch_addr held.
  - On ack the data is dropped (inst_valid stays 0), then ifetch_addr = 1C00_0200.
- Redirect simultaneous with id_stall and a full skid: skid and output are cleared, then fetch from the target.
- Misaligned target and wrap-around:
  - redir_pc = FFFF_FFFE → fetch FFFF_FFFC, next fetch 0000_0000.
- Reset mid-wait: cpu_rst asserted with a fetch outstanding → next cycle ifetch_req = 0 and pc = RESET_PC; the late ack is ignored.
